// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step restoring divide,
// MTHI/MTLO writes and the execute-stage stall for HI/LO hazards.
module muldiv_ctrl #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        mf_req,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_PREP = 3'd2,
    ST_DIV_RUN  = 3'd3,
    ST_DIV_FIX  = 3'd4
  } state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_ITER - 1);

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (32'd0 - v) : v;
  endfunction

  state_t      state_r, state_next_s;
  logic [4:0]  cnt_r, cnt_next_s;
  logic [31:0] a_r, b_r, hi_r, lo_r, rem_r;
  logic        sgn_r, qsign_r, rsign_r, done_r, div_zero_r;
  logic        accept_s, busy_s, done_next_s, div_zero_next_s;
  logic [32:0] rem_shift_s, diff_s;
  logic [63:0] ext_a_s, ext_b_s, prod_s;

  assign accept_s    = start && !flush && (state_r == ST_IDLE);
  assign busy_s      = (state_r != ST_IDLE);
  // a_r doubles as the dividend shift register; quotient bits enter at the bottom
  assign rem_shift_s = {rem_r, a_r[31]};
  assign diff_s      = rem_shift_s - {1'b0, b_r};
  assign ext_a_s     = {{32{sgn_r & a_r[31]}}, a_r};
  assign ext_b_s     = {{32{sgn_r & b_r[31]}}, b_r};
  assign prod_s      = ext_a_s * ext_b_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state, counter and output-pulse decode
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (flush) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_next_s = 5'd0;
          if (start) begin
            if (!op[1]) begin
              state_next_s = ST_MUL;
            end else if (src_b != 32'd0) begin
              state_next_s = ST_DIV_PREP;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == MUL_LAST) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = 5'd0;
          end else begin
            cnt_next_s = cnt_r + 5'd1;
          end
        end
        ST_DIV_PREP: begin
          state_next_s = ST_DIV_RUN;
          cnt_next_s   = 5'd0;
        end
        ST_DIV_RUN: begin
          if (cnt_r == DIV_LAST) begin
            state_next_s = ST_DIV_FIX;
            cnt_next_s   = 5'd0;
          end else begin
            cnt_next_s = cnt_r + 5'd1;
          end
        end
        ST_DIV_FIX: begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 5'd0;
        end
        default: begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 5'd0;
        end
      endcase
    end
    // done is raised for the cycle whose closing edge writes HI/LO
    done_next_s = !flush && (((state_next_s == ST_MUL) && (cnt_next_s == MUL_LAST)) ||
                             (state_next_s == ST_DIV_FIX));
    div_zero_next_s = accept_s && op[1] && (src_b == 32'd0);
  end

  // Operand latches, divide datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      rem_r      <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      sgn_r      <= 1'b0;
      qsign_r    <= 1'b0;
      rsign_r    <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= done_next_s;
      div_zero_r <= div_zero_next_s;
      if (flush) begin
        rem_r <= 32'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s) begin
              a_r   <= src_a;
              b_r   <= src_b;
              sgn_r <= ~op[0];
            end
            if (mthi) hi_r <= src_a;
            if (mtlo) lo_r <= src_a;
          end
          ST_MUL: begin
            if (cnt_r == MUL_LAST) begin
              hi_r <= prod_s[63:32];
              lo_r <= prod_s[31:0];
            end
          end
          ST_DIV_PREP: begin
            a_r     <= neg_if(a_r, sgn_r & a_r[31]);
            b_r     <= neg_if(b_r, sgn_r & b_r[31]);
            qsign_r <= sgn_r & (a_r[31] ^ b_r[31]);
            rsign_r <= sgn_r & a_r[31];
            rem_r   <= 32'd0;
          end
          ST_DIV_RUN: begin
            if (!diff_s[32]) begin
              rem_r <= diff_s[31:0];
              a_r   <= {a_r[30:0], 1'b1};
            end else begin
              rem_r <= rem_shift_s[31:0];
              a_r   <= {a_r[30:0], 1'b0};
            end
          end
          ST_DIV_FIX: begin
            lo_r <= neg_if(a_r, qsign_r);
            hi_r <= neg_if(rem_r, rsign_r);
          end
          default: begin
            rem_r <= 32'd0;
          end
        endcase
      end
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_s;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign stall    = (busy_s && (start || mf_req || mthi || mtlo)) || (accept_s && mf_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl: results come from plain 64-bit arithmetic,
// timing from the accept-to-write latencies (MUL_LAT for multiply, 34 for divide).
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 34;

  logic        clk, rst_n, start, mthi, mtlo, mf_req, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .mf_req(mf_req), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result {hi,lo} straight from integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = $signed(a); sb = $signed(b);
    ua = a;          ub = b;
    case (o)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      default: begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hilo(input string tag);
    chk_eq({tag, "_hi"}, hi, exp_hi);
    chk_eq({tag, "_lo"}, lo, exp_lo);
  endtask

  // Issue one operation (optionally with MTHI/MTLO in the accept cycle) and track it to completion
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic wh, input logic wl);
    logic [63:0] res;
    int          lat;
    start = 1'b1; op = o; src_a = a; src_b = b; mthi = wh; mtlo = wl;
    #1;
    chk_eq("idle_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    #1;
    if (wh) exp_hi = a;
    if (wl) exp_lo = a;
    if (o[1] && b == 32'd0) begin
      chk_eq("dz_pulse", {31'd0, div_zero}, 32'd1);
      chk_eq("dz_busy", {31'd0, busy}, 32'd0);
      chk_hilo("dz");
      tick(); #1;
      chk_eq("dz_end", {31'd0, div_zero}, 32'd0);
      chk_eq("dz_busy2", {31'd0, busy}, 32'd0);
      chk_eq("dz_done", {31'd0, done}, 32'd0);
      chk_hilo("dz2");
    end else begin
      lat = o[1] ? DIV_LAT : MUL_LAT;
      res = model(o, a, b);
      for (int k = 1; k <= lat; k++) begin
        chk_eq("run_busy", {31'd0, busy}, 32'd1);
        chk_eq("run_done", {31'd0, done}, (k == lat) ? 32'd1 : 32'd0);
        chk_eq("run_dz", {31'd0, div_zero}, 32'd0);
        chk_hilo("run_hold");
        tick(); #1;
      end
      exp_hi = res[63:32];
      exp_lo = res[31:0];
      chk_eq("end_busy", {31'd0, busy}, 32'd0);
      chk_eq("end_done", {31'd0, done}, 32'd0);
      chk_hilo("result");
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; src_a = h;
    tick();
    mthi = 1'b0; mtlo = 1'b1; src_a = l;
    tick();
    mtlo = 1'b0;
    exp_hi = h; exp_lo = l;
    #1;
    chk_hilo("mt");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] res;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0; flush = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    #12;
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_stall", {31'd0, stall}, 32'd0);
    chk_eq("rst_done", {31'd0, done}, 32'd0);
    chk_eq("rst_dz", {31'd0, div_zero}, 32'd0);
    chk_hilo("rst");
    rst_n = 1'b1;
    tick();

    // Directed multiplies and the divide overflow corner
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk_eq("mult_hi", hi, 32'hFFFF_FFFF);
    chk_eq("mult_lo", lo, 32'hFFFF_FFF1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk_eq("multu_hi", hi, 32'hFFFF_FFFE);
    chk_eq("multu_lo", lo, 32'h0000_0001);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk_eq("ovf_hi", hi, 32'h0000_0000);
    chk_eq("ovf_lo", lo, 32'h8000_0000);

    // DIV -7/2 with mf_req raised from cycle 5: stall holds until the cycle after done
    start = 1'b1; op = 2'd2; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    tick();
    start = 1'b0;
    for (int k = 1; k <= DIV_LAT; k++) begin
      mf_req = (k >= 5);
      #1;
      chk_eq("mf_stall", {31'd0, stall}, (k >= 5) ? 32'd1 : 32'd0);
      chk_eq("mf_done", {31'd0, done}, (k == DIV_LAT) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk_eq("mf_release", {31'd0, stall}, 32'd0);
    chk_eq("div_hi", hi, 32'hFFFF_FFFF);
    chk_eq("div_lo", lo, 32'hFFFF_FFFD);
    exp_hi = hi; exp_lo = lo;
    mf_req = 1'b0;
    tick();

    // DIVU 100/7 with a MULT held from cycle 2; it must be accepted right at IDLE
    start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    for (int k = 1; k <= DIV_LAT; k++) begin
      if (k >= 2) begin
        start = 1'b1; op = 2'd0; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
      end
      #1;
      chk_eq("hold_stall", {31'd0, stall}, (k >= 2) ? 32'd1 : 32'd0);
      chk_eq("hold_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    mf_req = 1'b1;
    #1;
    chk_eq("b2b_stall", {31'd0, stall}, 32'd1);
    chk_eq("b2b_idle", {31'd0, busy}, 32'd0);
    chk_eq("divu_hi", hi, 32'h0000_0002);
    chk_eq("divu_lo", lo, 32'h0000_000E);
    tick();
    start = 1'b0; mf_req = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      #1;
      chk_eq("b2b_busy", {31'd0, busy}, 32'd1);
      chk_eq("b2b_done", {31'd0, done}, (k == MUL_LAT) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    res = model(2'd0, 32'hFFFF_FFFD, 32'd5);
    exp_hi = res[63:32]; exp_lo = res[31:0];
    chk_hilo("b2b_mult");
    tick();

    // Divide by zero leaves HI/LO alone
    set_hilo(32'h11, 32'h22);
    run_op(2'd3, 32'h1234, 32'd0, 1'b0, 1'b0);
    chk_eq("dz_hi", hi, 32'h11);
    chk_eq("dz_lo", lo, 32'h22);

    // Flush at DIV_RUN iteration 10
    start = 1'b1; op = 2'd2; src_a = 32'h7654_3210; src_b = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      #1;
      chk_eq("fl_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk_eq("fl_idle", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 36; k++) begin
      chk_eq("fl_nodone", {31'd0, done}, 32'd0);
      chk_hilo("fl_hold");
      tick();
    end

    // flush together with start in IDLE: not accepted
    start = 1'b1; op = 2'd0; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    chk_eq("fl_start_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk_hilo("fl_start");

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      tick();
    end

    // Reset in the middle of a multiply
    set_hilo(32'hDEAD_BEEF, 32'hCAFE_F00D);
    start = 1'b1; op = 2'd1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk_hilo("arst");
    chk_eq("arst_busy", {31'd0, busy}, 32'd0);
    chk_eq("arst_done", {31'd0, done}, 32'd0);
    chk_eq("arst_stall", {31'd0, stall}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick(); tick();
    chk_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    chk_hilo("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
